// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//   Two-client round-robin arbiter in front of a simple dual-port BRAM
//   (one write port, one registered read port with 1-cycle latency).
//   The write and read ports have independent arbiters. Each grants at most
//   one client per cycle. Read results are steered back to the client that
//   issued the read by a valid strobe one cycle after the grant.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cN_wr_req/addr/data      client N write request (held until granted)
//   cN_wr_gnt                client N write accepted this cycle
//   cN_rd_req/addr           client N read request (held until granted)
//   cN_rd_gnt                client N read accepted this cycle
//   cN_rd_valid              rd_data carries client N's read result
//   rd_data                  shared read-return data (mem_rd_data passthrough)
//   mem_we/wr_addr/wr_data   BRAM write port
//   mem_rd_addr              BRAM read address
//   mem_rd_data              BRAM registered read data
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  c0_wr_req,
    input  logic [ADDR_WIDTH-1:0] c0_wr_addr,
    input  logic [DATA_WIDTH-1:0] c0_wr_data,
    output logic                  c0_wr_gnt,
    input  logic                  c0_rd_req,
    input  logic [ADDR_WIDTH-1:0] c0_rd_addr,
    output logic                  c0_rd_gnt,
    output logic                  c0_rd_valid,

    input  logic                  c1_wr_req,
    input  logic [ADDR_WIDTH-1:0] c1_wr_addr,
    input  logic [DATA_WIDTH-1:0] c1_wr_data,
    output logic                  c1_wr_gnt,
    input  logic                  c1_rd_req,
    input  logic [ADDR_WIDTH-1:0] c1_rd_addr,
    output logic                  c1_rd_gnt,
    output logic                  c1_rd_valid,

    output logic [DATA_WIDTH-1:0] rd_data,

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    // Favoured client for the next simultaneous request on each port.
    logic       wr_ptr;
    logic       rd_ptr;
    // Read-issue tag travelling alongside the BRAM's one-cycle read latency.
    logic [1:0] vld_p1;

    // ---- Stage 0: combinational grant and BRAM port muxing ----------------
    always_comb begin
        c0_wr_gnt = c0_wr_req & (~c1_wr_req | ~wr_ptr);
        c1_wr_gnt = c1_wr_req & (~c0_wr_req |  wr_ptr);
        c0_rd_gnt = c0_rd_req & (~c1_rd_req | ~rd_ptr);
        c1_rd_gnt = c1_rd_req & (~c0_rd_req |  rd_ptr);
    end

    always_comb begin
        mem_we      = c0_wr_gnt | c1_wr_gnt;
        // Client 0 is the idle default; harmless since mem_we is low then.
        mem_wr_addr = c1_wr_gnt ? c1_wr_addr : c0_wr_addr;
        mem_wr_data = c1_wr_gnt ? c1_wr_data : c0_wr_data;
        mem_rd_addr = c1_rd_gnt ? c1_rd_addr : c0_rd_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            vld_p1 <= 2'b00;
        end else begin
            // The pointer flips away from whoever was just served.
            if (c0_wr_gnt)      wr_ptr <= 1'b1;
            else if (c1_wr_gnt) wr_ptr <= 1'b0;

            if (c0_rd_gnt)      rd_ptr <= 1'b1;
            else if (c1_rd_gnt) rd_ptr <= 1'b0;

            vld_p1 <= {c1_rd_gnt, c0_rd_gnt};
        end
    end

    // ---- Stage 1: read data returns from the BRAM register ----------------
    always_comb begin
        c0_rd_valid = vld_p1[0];
        c1_rd_valid = vld_p1[1];
        rd_data     = mem_rd_data;
    end

endmodule
